axi_master: RTL and testbench



---
 rtl/axi_pkg.sv | 22 ++
 rtl/axi_master.sv | 178 +++++++++++++++++
 tb/tb_axi_master.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared definitions for the single-outstanding AXI burst master: widths,
// burst codes and FSM state encoding.
package axi_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned LEN_W  = 4;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StAw,
    StW,
    StB,
    StAr,
    StR
  } state_e;

endpackage

// File: rtl/axi_master.sv
// Single-outstanding AXI burst master: accepts one user command, issues the
// address phase, streams data beats through, and reports completion.
module axi_master
  import axi_pkg::*;
(
  input  logic              clk,
  input  logic              res_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [2:0]        cmd_size,
  input  logic [1:0]        cmd_burst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              done,
  output logic              done_resp,
  output logic              err,
  output logic              awvalid,
  input  logic              awready,
  output logic [ADDR_W-1:0] awaddr,
  output logic [LEN_W-1:0]  awlen,
  output logic [1:0]        awburst,
  output logic [2:0]        awsize,
  output logic              wvalid,
  input  logic              wready,
  output logic [DATA_W-1:0] wdata,
  output logic              wlast,
  output logic              bready,
  input  logic              bvalid,
  input  logic              bresp,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [LEN_W-1:0]  arlen,
  output logic [1:0]        arburst,
  output logic [2:0]        arsize,
  output logic              rready,
  input  logic              rvalid,
  input  logic [DATA_W-1:0] rdata,
  input  logic              rresp,
  input  logic              rlast
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [2:0]        size_q, size_d;
  logic [1:0]        burst_q, burst_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              resp_q, resp_d;
  logic              err_q, err_d;

  always_ff @(posedge clk) begin
    if (res_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      cnt_q   <= '0;
      resp_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
    end
  end

  // Address/control fields come straight from registers so they stay stable
  // for the whole address phase; only the valids are state-dependent.
  assign awaddr  = addr_q;
  assign awlen   = len_q;
  assign awsize  = size_q;
  assign awburst = burst_q;
  assign araddr  = addr_q;
  assign arlen   = len_q;
  assign arsize  = size_q;
  assign arburst = burst_q;
  assign wdata   = wr_data;
  assign rd_data = rdata;
  assign err     = err_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    len_d     = len_q;
    size_d    = size_q;
    burst_d   = burst_q;
    cnt_d     = cnt_q;
    resp_d    = resp_q;
    err_d     = err_q;
    cmd_ready = 1'b0;
    awvalid   = 1'b0;
    arvalid   = 1'b0;
    wvalid    = 1'b0;
    wr_ready  = 1'b0;
    wlast     = 1'b0;
    bready    = 1'b0;
    rready    = 1'b0;
    rd_valid  = 1'b0;
    rd_last   = 1'b0;
    done      = 1'b0;
    done_resp = 1'b0;

    case (state_q)
      StIdle: begin
        // Held low while reset is asserted so nothing looks ready mid-reset.
        cmd_ready = !res_n;
        if (cmd_valid && cmd_ready) begin
          addr_d  = cmd_addr;
          len_d   = cmd_len;
          size_d  = cmd_size;
          burst_d = cmd_burst;
          cnt_d   = '0;
          resp_d  = 1'b0;
          state_d = cmd_write ? StAw : StAr;
        end
      end
      StAw: begin
        awvalid = 1'b1;
        if (awready) state_d = StW;
      end
      StW: begin
        wvalid   = wr_valid;
        wr_ready = wready;
        wlast    = (cnt_q == len_q);
        if (wr_valid && wready) begin
          if (wlast) state_d = StB;
          else       cnt_d   = cnt_q + 1'b1;
        end
      end
      StB: begin
        bready = 1'b1;
        if (bvalid) begin
          done      = 1'b1;
          done_resp = bresp;
          state_d   = StIdle;
        end
      end
      StAr: begin
        arvalid = 1'b1;
        if (arready) state_d = StR;
      end
      StR: begin
        rready   = rd_ready;
        rd_valid = rvalid;
        rd_last  = rlast;
        if (rvalid && rd_ready) begin
          cnt_d  = cnt_q + 1'b1;
          resp_d = resp_q | rresp;
          // The peer's rlast decides completion; a disagreement with our
          // own beat count is only flagged.
          if (rlast != (cnt_q == len_q)) err_d = 1'b1;
          if (rlast) begin
            done      = 1'b1;
            done_resp = resp_q | rresp;
            state_d   = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_axi_master.sv
// Bench for axi_master: a memory-backed peer model plus randomized write and
// read-back bursts, with fixed cases for backpressure, rlast errors and reset.
module tb_axi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        res_n, cmd_valid, cmd_ready, cmd_write;
  logic [4:0]  cmd_addr;
  logic [3:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic        wr_valid, wr_ready;
  logic [15:0] wr_data;
  logic        rd_valid, rd_ready, rd_last;
  logic [15:0] rd_data;
  logic        done, done_resp, err;
  logic        awvalid, awready;
  logic [4:0]  awaddr, araddr;
  logic [3:0]  awlen, arlen;
  logic [1:0]  awburst, arburst;
  logic [2:0]  awsize, arsize;
  logic        wvalid, wready, wlast;
  logic [15:0] wdata, rdata;
  logic        bready, bvalid, bresp;
  logic        arvalid, arready;
  logic        rready, rvalid, rresp, rlast;

  axi_master u_dut (
    .clk       (clk),
    .res_n     (res_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .cmd_size  (cmd_size),
    .cmd_burst (cmd_burst),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_last   (rd_last),
    .done      (done),
    .done_resp (done_resp),
    .err       (err),
    .awvalid   (awvalid),
    .awready   (awready),
    .awaddr    (awaddr),
    .awlen     (awlen),
    .awburst   (awburst),
    .awsize    (awsize),
    .wvalid    (wvalid),
    .wready    (wready),
    .wdata     (wdata),
    .wlast     (wlast),
    .bready    (bready),
    .bvalid    (bvalid),
    .bresp     (bresp),
    .arvalid   (arvalid),
    .arready   (arready),
    .araddr    (araddr),
    .arlen     (arlen),
    .arburst   (arburst),
    .arsize    (arsize),
    .rready    (rready),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .rresp     (rresp),
    .rlast     (rlast)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [15:0] mem [32];
  bit          exp_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0; cmd_size = '0; cmd_burst = '0;
    wr_valid = 0; wr_data = '0; rd_ready = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0;
    rvalid = 0; rdata = '0; rresp = 0; rlast = 0;
  endtask

  task automatic do_reset(input int cycles);
    res_n = 1;
    repeat (cycles) begin
      tick();
      check_eq("rst_awvalid", awvalid, 0);
      check_eq("rst_wvalid", wvalid, 0);
      check_eq("rst_arvalid", arvalid, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_cmd_ready", cmd_ready, 0);
    end
    res_n = 0;
    idle_inputs();
    #1;
    check_eq("rel_cmd_ready", cmd_ready, 1);
    check_eq("rel_err", err, 0);
    exp_err = 0;
  endtask

  task automatic send_cmd(input bit wr, input logic [4:0] a, input logic [3:0] l,
                          input logic [2:0] sz, input logic [1:0] bt);
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_len = l; cmd_size = sz; cmd_burst = bt;
    #1;
    check_eq("cmd_ready", cmd_ready, 1);
    check_eq("pre_cmd_valid", awvalid | arvalid, 0);
    tick();
    cmd_valid = 0; cmd_addr = '0; cmd_len = '0; cmd_size = '0; cmd_burst = '0;
  endtask

  task automatic run_write(input logic [4:0] a, input logic [3:0] l, input logic [2:0] sz,
                           input logic [1:0] bt, input int aw_stall, input bit rnd,
                           input logic br, input logic [15:0] d [16], input int abort_after);
    int k;
    int cyc;
    send_cmd(1, a, l, sz, bt);
    for (int i = 0; i <= aw_stall; i++) begin
      awready = (i == aw_stall);
      #1;
      check_eq("awvalid", awvalid, 1);
      check_eq("awaddr", awaddr, a);
      check_eq("awlen", awlen, l);
      check_eq("awsize", awsize, sz);
      check_eq("awburst", awburst, bt);
      tick();
    end
    awready = 0;
    k = 0;
    cyc = 0;
    while (k <= int'(l) && cyc < 200) begin
      wr_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      wready   = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      wr_data  = d[k];
      #1;
      check_eq("wvalid", wvalid, wr_valid);
      check_eq("wr_ready", wr_ready, wready);
      if (wr_valid && wready) begin
        check_eq("wdata", wdata, d[k]);
        check_eq("wlast", wlast, (k == int'(l)));
        mem[(int'(a) + k) % 32] = d[k];
        k++;
      end
      cyc++;
      tick();
      if (abort_after >= 0 && k == abort_after) return;
    end
    if (cyc >= 200) check_eq("w_timeout", 0, 1);
    if (!rnd) check_eq("w_throughput", cyc, int'(l) + 1);
    wr_valid = 0; wready = 0;
    repeat ($urandom_range(0, 2)) begin
      #1;
      check_eq("bready", bready, 1);
      check_eq("b_done_early", done, 0);
      tick();
    end
    bvalid = 1; bresp = br;
    #1;
    check_eq("b_done", done, 1);
    check_eq("b_done_resp", done_resp, br);
    tick();
    bvalid = 0; bresp = 0;
    #1;
    check_eq("w_idle", cmd_ready, 1);
    check_eq("w_done_clear", done, 0);
  endtask

  // mode: 0 = user always ready, 1 = toggle every cycle, 2 = random.
  task automatic run_read(input logic [4:0] a, input logic [3:0] l, input int mode,
                          input int last_idx, input bit rnd_valid);
    int  k;
    int  cyc;
    bit  acc;
    bit  fin;
    send_cmd(0, a, l, 3'b001, 2'b01);
    repeat ($urandom_range(0, 2)) begin
      #1;
      check_eq("arvalid_stall", arvalid, 1);
      check_eq("araddr_stall", araddr, a);
      tick();
    end
    arready = 1;
    #1;
    check_eq("arvalid", arvalid, 1);
    check_eq("araddr", araddr, a);
    check_eq("arlen", arlen, l);
    check_eq("ar_no_aw", awvalid, 0);
    tick();
    arready = 0;
    k = 0; cyc = 0; acc = 0; fin = 0;
    while (!fin && cyc < 200) begin
      rvalid   = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      rdata    = mem[(int'(a) + k) % 32];
      rresp    = ($urandom_range(0, 3) == 0);
      rlast    = (k == last_idx);
      rd_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'((cyc % 2) == 0) : 1'($urandom_range(0, 1));
      #1;
      check_eq("rready", rready, rd_ready);
      check_eq("rd_valid", rd_valid, rvalid);
      if (rvalid && rd_ready) begin
        check_eq("rd_data", rd_data, mem[(int'(a) + k) % 32]);
        check_eq("rd_last", rd_last, rlast);
        acc |= rresp;
        if ((k == int'(l)) != rlast) exp_err = 1;
        if (rlast) begin
          check_eq("r_done", done, 1);
          check_eq("r_done_resp", done_resp, acc);
          fin = 1;
        end else begin
          check_eq("r_done_early", done, 0);
        end
        k++;
      end else begin
        check_eq("r_done_idle", done, 0);
      end
      cyc++;
      tick();
    end
    if (!fin) check_eq("r_timeout", 0, 1);
    rvalid = 0; rd_ready = 0; rlast = 0; rresp = 0;
    #1;
    check_eq("r_beats", k, last_idx + 1);
    check_eq("r_idle", cmd_ready, 1);
    check_eq("r_err", err, exp_err);
  endtask

  initial begin
    logic [15:0] d [16];
    logic [4:0]  a;
    logic [3:0]  l;
    int          li;
    idle_inputs();
    exp_err = 0;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    for (int i = 0; i < 16; i++) d[i] = '0;
    do_reset(2);

    d[0] = 16'hff11; d[1] = 16'h11aa; d[2] = 16'h0011; d[3] = 16'h1110;
    run_write(5'd0, 4'd3, 3'b001, 2'b01, 3, 0, 1'b0, d, -1);
    run_read(5'd0, 4'd3, 0, 3, 0);
    run_read(5'd0, 4'd3, 1, 3, 0);
    run_read(5'd0, 4'd3, 0, 1, 0);
    check_eq("early_rlast_err", err, 1);

    // Reset in the middle of a write burst, with user data still offered.
    do_reset(1);
    run_write(5'd4, 4'd3, 3'b001, 2'b01, 0, 0, 1'b0, d, 2);
    wr_valid = 1; wready = 1;
    do_reset(1);
    check_eq("post_rst_wvalid", wvalid, 0);

    for (int it = 0; it < 30; it++) begin
      a = 5'($urandom_range(0, 31));
      l = 4'($urandom_range(0, 15));
      for (int i = 0; i < 16; i++) d[i] = 16'($urandom);
      run_write(a, l, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 2)),
                $urandom_range(0, 3), 1, 1'($urandom_range(0, 1)), d, -1);
      li = int'(l);
      case ($urandom_range(0, 5))
        0: if (li > 0) li = li - 1;
        1: if (li < 15) li = li + 1;
        default: ;
      endcase
      run_read(a, l, $urandom_range(0, 2), li, 1'($urandom_range(0, 1)));
      if (exp_err && $urandom_range(0, 1) == 1) do_reset(1);
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
